// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, ALU-operation and condition-code definitions for mc_control_unit
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_UNDEF
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_EOR = 3'b100;
   localparam logic [2:0] ALU_MUL = 3'b101;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/mc_cond_check.sv
// rtl/mc_cond_check.sv - NZCV flag register and ARM condition evaluation
module mc_cond_check
   import mc_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   output logic       CondEx
);

   logic [3:0] flags_q;
   logic [3:0] flags_d;
   logic       n, z, c, v;
   logic       cond_ex;

   assign {n, z, c, v} = flags_q;
   assign CondEx = cond_ex;

   // Evaluate the condition field against the registered (old) flags
   always_comb begin
      cond_ex = 1'b0;
      case (Cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = !z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = !c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = !n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = !v;
         COND_HI: cond_ex = c && !z;
         COND_LS: cond_ex = !c || z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = !z && (n == v);
         COND_LE: cond_ex = z || (n != v);
         COND_AL: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // NZ and CV halves update independently, only when the instruction executes
   always_comb begin
      flags_d = flags_q;
      if (FlagW[1] && cond_ex) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0] && cond_ex) flags_d[1:0] = ALUFlags[1:0];
   end

   // Flag register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) flags_q <= RESET_FLAGS;
      else       flags_q <= flags_d;
   end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle ARM control unit; define CTRL_MUL_EN to decode MUL
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int         ALUCTRL_W   = 3,
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           Op,
   input  logic [5:0]           Funct,
   input  logic [3:0]           Rd,
   input  logic [3:0]           Cond,
   input  logic [3:0]           Instr74,
   input  logic [3:0]           ALUFlags,
   input  logic                 MemReady,
   output logic                 PCWrite,
   output logic                 RegWrite,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 AdrSrc,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ImmSrc,
   output logic [1:0]           RegSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 Undef
);

   state_t     state_q, state_d;
   logic       next_pc, reg_w, mem_w, branch, alu_op;
   logic [2:0] alu_ctl;
   logic [1:0] flag_w;
   logic       known_op;
   logic       is_cmp;
   logic       cond_ex;
   logic       pcs;

`ifndef CTRL_MUL_EN
   logic unused_instr74;
   assign unused_instr74 = ^Instr74;
`endif

   assign is_cmp = (Funct[4:1] == 4'b1010);

   // Next-state selection; stalls hold in FETCH, MEMRD and MEMWR until MemReady
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (MemReady) state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_UNDEF;
            endcase
         end
         S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (MemReady) state_d = S_MEMWB;
         S_MEMWR:  if (MemReady) state_d = S_FETCH;
         S_EXECR,
         S_EXECI:  state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // Per-state datapath controls and raw (ungated) write requests
   always_comb begin
      next_pc   = 1'b0;
      reg_w     = 1'b0;
      mem_w     = 1'b0;
      branch    = 1'b0;
      alu_op    = 1'b0;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      Undef     = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MemReady;
            next_pc   = MemReady;
         end
         S_DECODE: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_MEMADR: ALUSrcB = 2'b01;
         S_MEMRD:  AdrSrc  = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_w     = 1'b1;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1;
            mem_w  = 1'b1;
         end
         S_EXECR:  alu_op = 1'b1;
         S_EXECI: begin
            ALUSrcB = 2'b01;
            alu_op  = 1'b1;
         end
         S_ALUWB:  reg_w = !is_cmp;
         S_BRANCH: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            branch    = 1'b1;
         end
         S_UNDEF:  Undef = 1'b1;
         default: ;
      endcase
   end

   // ALU operation and flag-write decode; unrecognised codes add without touching flags
   always_comb begin
      alu_ctl  = ALU_ADD;
      flag_w   = 2'b00;
      known_op = 1'b1;
      if (alu_op) begin
         case (Funct[4:1])
            4'b0100: alu_ctl = ALU_ADD;
            4'b0010: alu_ctl = ALU_SUB;
            4'b0000: alu_ctl = ALU_AND;
            4'b1100: alu_ctl = ALU_ORR;
            4'b0001: alu_ctl = ALU_EOR;
            4'b1010: alu_ctl = ALU_SUB;
            default: known_op = 1'b0;
         endcase
`ifdef CTRL_MUL_EN
         if (Op == 2'b00 && !Funct[5] && Funct[4:1] == 4'b0000 && Instr74 == 4'b1001)
            alu_ctl = ALU_MUL;
`endif
         flag_w[1] = Funct[0] && known_op;
         flag_w[0] = Funct[0] && known_op && (alu_ctl == ALU_ADD || alu_ctl == ALU_SUB);
      end
   end

   // Upper ALUControl bits stay zero for widths above the native three
   always_comb begin
      ALUControl      = '0;
      ALUControl[2:0] = alu_ctl;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   mc_cond_check #(
      .RESET_FLAGS(RESET_FLAGS)
   ) u_cond (
      .clk      (clk),
      .reset    (reset),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .FlagW    (flag_w),
      .CondEx   (cond_ex)
   );

   assign ImmSrc   = Op;
   assign RegSrc   = {Op == 2'b01, Op == 2'b10};
   assign pcs      = ((Rd == 4'd15) && reg_w) || branch;
   assign PCWrite  = (pcs && cond_ex) || next_pc;
   assign RegWrite = reg_w && cond_ex;
   assign MemWrite = mem_w && cond_ex;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - self-checking bench for mc_control_unit against an instruction-level model
module tb_mc_control_unit;

   localparam int         AW = 4;
   localparam logic [3:0] RF = 4'b1001;

   localparam int ST_F  = 0;
   localparam int ST_D  = 1;
   localparam int ST_A  = 2;
   localparam int ST_R  = 3;
   localparam int ST_W  = 4;
   localparam int ST_S  = 5;
   localparam int ST_XR = 6;
   localparam int ST_XI = 7;
   localparam int ST_AW = 8;
   localparam int ST_B  = 9;
   localparam int ST_U  = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    Op;
   logic [5:0]    Funct;
   logic [3:0]    Rd, Cond, Instr74, ALUFlags;
   logic          MemReady;
   logic          PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, Undef;
   logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
   logic [AW-1:0] ALUControl;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] m_flags;
   int         c_cyc, c_ir, c_reg, c_pc, c_mem, c_und;

   mc_control_unit #(.ALUCTRL_W(AW), .RESET_FLAGS(RF)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
      .Instr74(Instr74), .ALUFlags(ALUFlags), .MemReady(MemReady),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Undef(Undef)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] pack_obs();
      return {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
              ImmSrc, RegSrc, ALUControl, Undef};
   endfunction

   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // {operation[3:0], writes NZ, writes CV, is compare}
   function automatic logic [6:0] alu_model(input logic [1:0] op, input logic [5:0] funct,
                                            input logic [3:0] i74);
      logic [3:0] ctl;
      bit s, nz, cv;
      s = funct[0];
      nz = 1'b0;
      cv = 1'b0;
      case (funct[4:1])
         4'b0100: begin ctl = 4'd0; nz = s; cv = s; end
         4'b0010: begin ctl = 4'd1; nz = s; cv = s; end
         4'b0000: begin ctl = 4'd2; nz = s; end
         4'b1100: begin ctl = 4'd3; nz = s; end
         4'b0001: begin ctl = 4'd4; nz = s; end
         4'b1010: begin ctl = 4'd1; nz = s; cv = s; end
         default: ctl = 4'd0;
      endcase
`ifdef CTRL_MUL_EN
      if (op == 2'b00 && !funct[5] && funct[4:1] == 4'b0000 && i74 == 4'b1001) begin
         ctl = 4'd5;
         cv  = 1'b0;
      end
`else
      if (op == 2'b11 && i74 == 4'hF) ctl = ctl;
`endif
      return {ctl, nz, cv, funct[4:1] == 4'b1010};
   endfunction

   function automatic logic [19:0] model_out(input int st, input bit mr, input bit pass,
                                             input logic [1:0] op, input logic [5:0] funct,
                                             input logic [3:0] rd, input logic [3:0] i74);
      bit pcw, rw, mw, irw, adr, und;
      logic [1:0] rs, sa, sb;
      logic [3:0] ctl;
      logic [6:0] am;
      am = alu_model(op, funct, i74);
      {pcw, rw, mw, irw, adr, und} = 6'b0;
      rs = 2'b00; sa = 2'b00; sb = 2'b00; ctl = 4'd0;
      case (st)
         ST_F:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
         ST_D:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
         ST_A:  sb = 2'b01;
         ST_R:  adr = 1'b1;
         ST_W:  begin rs = 2'b01; rw = pass; pcw = pass && rd == 4'd15; end
         ST_S:  begin adr = 1'b1; mw = pass; end
         ST_XR: ctl = am[6:3];
         ST_XI: begin sb = 2'b01; ctl = am[6:3]; end
         ST_AW: begin rw = pass && !am[0]; pcw = rw && rd == 4'd15; end
         ST_B:  begin sa = 2'b10; sb = 2'b01; rs = 2'b10; pcw = pass; end
         default: und = 1'b1;
      endcase
      return {pcw, rw, mw, irw, adr, rs, sa, sb, op, {op == 2'b01, op == 2'b10}, ctl, und};
   endfunction

   task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                            input logic [3:0] cond, input logic [3:0] i74,
                            input logic [31:0] mrpat, input logic [3:0] af, input bit rnd);
      int steps[$];
      int idx, st;
      bit mr, pass;
      logic [6:0] am;
      steps = {ST_F, ST_D};
      case (op)
         2'b00: begin steps.push_back(funct[5] ? ST_XI : ST_XR); steps.push_back(ST_AW); end
         2'b01: begin
            steps.push_back(ST_A);
            if (funct[0]) begin steps.push_back(ST_R); steps.push_back(ST_W); end
            else steps.push_back(ST_S);
         end
         2'b10: steps.push_back(ST_B);
         default: steps.push_back(ST_U);
      endcase
      Op = op; Funct = funct; Rd = rd; Cond = cond; Instr74 = i74;
      {c_cyc, c_ir, c_reg, c_pc, c_mem, c_und} = {6{32'sd0}};
      idx = 0;
      while (idx < steps.size()) begin
         st = steps[idx];
         if (rnd) begin
            mr = (c_cyc > 24) ? 1'b1 : ($urandom_range(0, 3) != 0);
            ALUFlags = 4'($urandom);
         end else begin
            mr = (c_cyc < 32) ? mrpat[c_cyc] : 1'b1;
            ALUFlags = af;
         end
         MemReady = mr;
         #2;
         pass = cond_ok(cond, m_flags);
         chk($sformatf("outputs cyc%0d step%0d op%0d funct%h", c_cyc, st, op, funct),
             {12'd0, pack_obs()}, {12'd0, model_out(st, mr, pass, op, funct, rd, i74)});
         c_ir  += int'(IRWrite);
         c_reg += int'(RegWrite);
         c_pc  += int'(PCWrite);
         c_mem += int'(MemWrite);
         c_und += int'(Undef);
         @(posedge clk);
         if ((st == ST_XR || st == ST_XI) && pass) begin
            am = alu_model(op, funct, i74);
            if (am[2]) m_flags[3:2] = ALUFlags[3:2];
            if (am[1]) m_flags[1:0] = ALUFlags[1:0];
         end
         if (!((st == ST_F || st == ST_R || st == ST_S) && !mr)) idx++;
         c_cyc++;
         #1;
      end
      chk($sformatf("flags after op%0d funct%h", op, funct), {28'd0, dut.u_cond.flags_q},
          {28'd0, m_flags});
   endtask

   initial begin
      reset = 1'b1;
      Op = 2'b00; Funct = 6'd0; Rd = 4'd0; Cond = 4'hE; Instr74 = 4'd0;
      ALUFlags = 4'd0; MemReady = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs_mr1", {12'd0, pack_obs()}, {12'd0, model_out(ST_F, 1'b1, 1'b1, 2'b00, 6'd0, 4'd0, 4'd0)});
      chk("reset_flags", {28'd0, dut.u_cond.flags_q}, {28'd0, RF});
      MemReady = 1'b0;
      #1;
      chk("reset_outputs_mr0", {12'd0, pack_obs()}, {12'd0, model_out(ST_F, 1'b0, 1'b1, 2'b00, 6'd0, 4'd0, 4'd0)});
      reset = 1'b0;
      m_flags = RF;

      run_instr(2'b10, 6'b100000, 4'd0, 4'h0, 4'd0, '1, 4'd0, 1'b0);
      chk("beq_after_reset_pcw", c_pc, 1);
      run_instr(2'b10, 6'b100000, 4'd0, 4'h4, 4'd0, '1, 4'd0, 1'b0);
      chk("bmi_after_reset_pcw", c_pc, 2);

      run_instr(2'b00, 6'b001000, 4'd1, 4'hE, 4'd0, '1, 4'd0, 1'b0);
      chk("add_regwrite", c_reg, 1);

      run_instr(2'b00, 6'b000101, 4'd0, 4'hE, 4'd0, '1, 4'b0100, 1'b0);
      chk("subs_flags", {28'd0, dut.u_cond.flags_q}, 32'h4);
      run_instr(2'b10, 6'b100000, 4'd0, 4'h0, 4'd0, '1, 4'd0, 1'b0);
      chk("beq_taken_pcw", c_pc, 2);
      run_instr(2'b10, 6'b100000, 4'd0, 4'h1, 4'd0, '1, 4'd0, 1'b0);
      chk("bne_not_taken_pcw", c_pc, 1);

      run_instr(2'b01, 6'b011001, 4'd2, 4'hE, 4'd0, 32'hFFFF_FF1C, 4'd0, 1'b0);
      chk("ldr_irwrite_pulses", c_ir, 1);
      chk("ldr_regwrite", c_reg, 1);
      run_instr(2'b01, 6'b011000, 4'd3, 4'hE, 4'd0, '1, 4'd0, 1'b0);
      chk("str_memwrite", c_mem, 1);

      run_instr(2'b00, 6'b000011, 4'd15, 4'hE, 4'd0, '1, 4'hF, 1'b0);
      chk("eor_pc_pcw", c_pc, 2);
      chk("eor_flags", {28'd0, dut.u_cond.flags_q}, 32'hC);

      run_instr(2'b11, 6'b000000, 4'd5, 4'hE, 4'd0, '1, 4'd0, 1'b0);
      chk("undef_pulse", c_und, 1);
      chk("undef_no_reg", c_reg, 0);
      chk("undef_no_mem", c_mem, 0);

      run_instr(2'b00, 6'b000001, 4'd6, 4'hE, 4'b1001, '1, 4'd0, 1'b0);
      run_instr(2'b00, 6'b010101, 4'd3, 4'hE, 4'd0, '1, 4'b0010, 1'b0);
      chk("cmp_no_regwrite", c_reg, 0);

      Op = 2'b01; Funct = 6'b011000; Rd = 4'd4; Cond = 4'hE; MemReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      MemReady = 1'b0;
      #2;
      chk("memwr_memwrite", {31'd0, MemWrite}, 32'd1);
      @(posedge clk);
      #1;
      chk("memwr_stall_memwrite", {31'd0, MemWrite}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("async_reset_memwrite", {31'd0, MemWrite}, 32'd0);
      chk("async_reset_outputs", {12'd0, pack_obs()}, {12'd0, model_out(ST_F, 1'b0, 1'b1, 2'b01, 6'b011000, 4'd4, 4'd0)});
      chk("async_reset_flags", {28'd0, dut.u_cond.flags_q}, {28'd0, RF});
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_flags = RF;

      for (int k = 0; k < 250; k++) begin
         run_instr(2'($urandom), 6'($urandom),
                   ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
                   ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom),
                   ($urandom_range(0, 1) == 0) ? 4'b1001 : 4'($urandom),
                   '1, 4'd0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
